// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
//
// Purpose:
//    Per-register scoreboard for the dual-issue pipeline. It counts the
//    long-latency writes (mul, div, load) that are still outstanding for each
//    architectural GPR, from issue until writeback. From that state it gives
//    each issue slot a ready qualifier, which the issue stage ANDs into its
//    own issue decision.
//
//    Hazards inside an issue pair (WAW/RAW inside the pair, structural
//    conflicts) are checked in the issue stage. This block does not repeat
//    those checks.
//
// Ports:
//    clk          core clock
//    rst_n        asynchronous active-low reset
//    flush_i      pipeline flush; every long op in flight is killed
//    is_fire_i    [2]      slot k actually issues this cycle
//    is_long_i    [2]      slot k is a long-latency register writer
//    is_w_reg_i   [2][5]   destination register of issuing slot k
//    chk_r_reg_i  [2][2][5] source registers of the candidate in slot k
//    chk_w_reg_i  [2][5]   destination register of the candidate in slot k
//    wb_valid_i   [2]      long-latency writeback port j completes
//    wb_w_reg_i   [2][5]   register written by writeback port j
//    ready_o      [2]      slot k is clear of outstanding long writes
//    busy_mask_o  [REG_NUM] registered; bit r set while cnt[r] != 0
//    underflow_o  sticky flag: a writeback arrived for a register at count 0
// -----------------------------------------------------------------------------
module reg_scoreboard #(
   parameter int REG_NUM = 32,
   parameter int CNT_W   = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush_i,
   input  logic [1:0]           is_fire_i,
   input  logic [1:0]           is_long_i,
   input  logic [1:0][4:0]      is_w_reg_i,
   input  logic [1:0][1:0][4:0] chk_r_reg_i,
   input  logic [1:0][4:0]      chk_w_reg_i,
   input  logic [1:0]           wb_valid_i,
   input  logic [1:0][4:0]      wb_w_reg_i,
   output logic [1:0]           ready_o,
   output logic [REG_NUM-1:0]   busy_mask_o,
   output logic                 underflow_o
);

   // Two extra bits give headroom for +2 and a sign bit for -2.
   localparam int             SUM_W = CNT_W + 2;
   localparam logic [CNT_W-1:0] CMAX  = '1;

   logic [REG_NUM-1:0][CNT_W-1:0] cnt_q;
   logic [REG_NUM-1:0][CNT_W-1:0] cnt_d;
   logic [REG_NUM-1:0]            busy_d;
   logic                          underflow_d;
   logic [SUM_W-1:0]              inc;
   logic [SUM_W-1:0]              dec;
   logic [SUM_W-1:0]              sum;

   // Next-state counters. For each tracked register, add the long issues
   // that target it and subtract the writebacks that hit it. The result is
   // read as two's complement. A negative result clamps to zero and raises
   // the sticky underflow flag. A result above CMAX means the issue stage
   // broke protocol. It saturates silently, because the ready logic should
   // already have stopped that issue. r0 is never tracked. A flush wipes
   // every counter and discards the issues and writebacks of that cycle. It
   // does not touch the sticky flag.
   always_comb begin
      cnt_d       = cnt_q;
      underflow_d = underflow_o;
      inc         = '0;
      dec         = '0;
      sum         = '0;
      for (int r = 1; r < REG_NUM; r++) begin
         inc = '0;
         dec = '0;
         for (int k = 0; k < 2; k++) begin
            if (is_fire_i[k] && is_long_i[k] && (is_w_reg_i[k] == 5'(r))) begin
               inc = inc + SUM_W'(1);
            end
         end
         for (int j = 0; j < 2; j++) begin
            if (wb_valid_i[j] && (wb_w_reg_i[j] == 5'(r))) begin
               dec = dec + SUM_W'(1);
            end
         end
         sum = SUM_W'(cnt_q[r]) + inc - dec;
         if (sum[SUM_W-1]) begin
            cnt_d[r]    = '0;
            underflow_d = 1'b1;
         end else if (sum > SUM_W'(CMAX)) begin
            cnt_d[r] = CMAX;
         end else begin
            cnt_d[r] = sum[CNT_W-1:0];
         end
      end
      cnt_d[0] = '0;
      if (flush_i) begin
         cnt_d       = '0;
         underflow_d = underflow_o;
      end
   end

   // The busy vector comes from the next-state counters. After the clock
   // edge the registered mask therefore matches the counters that ready_o
   // sees.
   always_comb begin
      busy_d = '0;
      for (int r = 1; r < REG_NUM; r++) begin
         busy_d[r] = (cnt_d[r] != '0);
      end
   end

   // State registers: counters, busy mask and the sticky underflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         busy_mask_o <= '0;
         underflow_o <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         busy_mask_o <= busy_d;
         underflow_o <= underflow_d;
      end
   end

   // Ready qualifiers use registered state only. A writeback in the current
   // cycle does not bypass into readiness. The slot becomes ready the cycle
   // after its counters drain. A busy destination blocks WAW against a long
   // op. The CMAX term keeps the counter from saturating. It is redundant
   // while the busy check is also blocking.
   always_comb begin
      ready_o = '0;
      for (int k = 0; k < 2; k++) begin
         ready_o[k] = !((chk_r_reg_i[k][0] != 5'd0) && busy_mask_o[chk_r_reg_i[k][0]])
                   && !((chk_r_reg_i[k][1] != 5'd0) && busy_mask_o[chk_r_reg_i[k][1]])
                   && !((chk_w_reg_i[k]    != 5'd0) && busy_mask_o[chk_w_reg_i[k]])
                   && (cnt_q[chk_w_reg_i[k]] != CMAX);
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_reg_scoreboard
//
// Purpose:
//    Directed bench for reg_scoreboard. Each scenario task drives its own
//    stimulus. It compares the outputs against hand-computed values.
//    Inputs change 1 time unit after a rising edge. Outputs are sampled 1
//    time unit later, well away from the next edge.
//
// Ports:
//    none (top-level bench)
// -----------------------------------------------------------------------------
module tb_reg_scoreboard;

   logic                 clk;
   logic                 rst_n;
   logic                 flush_i;
   logic [1:0]           is_fire_i;
   logic [1:0]           is_long_i;
   logic [1:0][4:0]      is_w_reg_i;
   logic [1:0][1:0][4:0] chk_r_reg_i;
   logic [1:0][4:0]      chk_w_reg_i;
   logic [1:0]           wb_valid_i;
   logic [1:0][4:0]      wb_w_reg_i;
   logic [1:0]           ready_o;
   logic [31:0]          busy_mask_o;
   logic                 underflow_o;

   int checks;
   int errors;

   reg_scoreboard #(.REG_NUM(32), .CNT_W(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush_i),
      .is_fire_i   (is_fire_i),
      .is_long_i   (is_long_i),
      .is_w_reg_i  (is_w_reg_i),
      .chk_r_reg_i (chk_r_reg_i),
      .chk_w_reg_i (chk_w_reg_i),
      .wb_valid_i  (wb_valid_i),
      .wb_w_reg_i  (wb_w_reg_i),
      .ready_o     (ready_o),
      .busy_mask_o (busy_mask_o),
      .underflow_o (underflow_o)
   );

   // 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Return every non-reset input to idle.
   task automatic clear_inputs();
      flush_i     = 1'b0;
      is_fire_i   = '0;
      is_long_i   = '0;
      is_w_reg_i  = '0;
      chk_r_reg_i = '0;
      chk_w_reg_i = '0;
      wb_valid_i  = '0;
      wb_w_reg_i  = '0;
   endtask

   // Move to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a long op on one slot.
   task automatic issue(input int slot, input logic [4:0] rd);
      is_fire_i[slot]  = 1'b1;
      is_long_i[slot]  = 1'b1;
      is_w_reg_i[slot] = rd;
   endtask

   // Drive one writeback port.
   task automatic writeback(input int port, input logic [4:0] rd);
      wb_valid_i[port] = 1'b1;
      wb_w_reg_i[port] = rd;
   endtask

   // Reset state: nothing busy, both slots ready, no underflow.
   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      chk_r_reg_i[0][0] = 5'd5;
      chk_r_reg_i[1][1] = 5'd31;
      chk_w_reg_i[0]    = 5'd7;
      chk_w_reg_i[1]    = 5'd1;
      #2;
      checks++;
      if (busy_mask_o !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_busy: got %h expected %h", busy_mask_o, 32'h0);
      end
      checks++;
      if (underflow_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_underflow: got %b expected 0", underflow_o);
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      #1;
      checks++;
      if (ready_o !== 2'b11) begin
         errors++;
         $display("[TB] FAIL idle_ready: got %b expected 11", ready_o);
      end
      checks++;
      if (busy_mask_o !== 32'h0) begin
         errors++;
         $display("[TB] FAIL idle_busy: got %h expected %h", busy_mask_o, 32'h0);
      end
   endtask

   // Single long issue to r5, then its writeback. No same-cycle bypass.
   task automatic test_single_issue();
      clear_inputs();
      issue(0, 5'd5);
      tick();
      clear_inputs();
      chk_r_reg_i[0][0] = 5'd5;
      chk_w_reg_i[1]    = 5'd5;
      #1;
      checks++;
      if (ready_o !== 2'b00) begin
         errors++;
         $display("[TB] FAIL r5_busy_ready: got %b expected 00", ready_o);
      end
      checks++;
      if (busy_mask_o !== 32'h0000_0020) begin
         errors++;
         $display("[TB] FAIL r5_busy_mask: got %h expected %h", busy_mask_o, 32'h20);
      end
      writeback(0, 5'd5);
      #1;
      checks++;
      if (ready_o[0] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL r5_no_bypass: got %b expected 0", ready_o[0]);
      end
      tick();
      wb_valid_i = '0;
      #1;
      checks++;
      if (ready_o !== 2'b11) begin
         errors++;
         $display("[TB] FAIL r5_ready_after_wb: got %b expected 11", ready_o);
      end
      checks++;
      if (busy_mask_o !== 32'h0) begin
         errors++;
         $display("[TB] FAIL r5_clear_mask: got %h expected %h", busy_mask_o, 32'h0);
      end
   endtask

   // Issue and writeback on r7 in the same cycle while cnt[7] = 1.
   task automatic test_same_cycle();
      clear_inputs();
      issue(1, 5'd7);
      tick();
      clear_inputs();
      issue(0, 5'd7);
      writeback(1, 5'd7);
      tick();
      clear_inputs();
      #1;
      checks++;
      if (busy_mask_o !== 32'h0000_0080) begin
         errors++;
         $display("[TB] FAIL r7_net_zero: got %h expected %h", busy_mask_o, 32'h80);
      end
      writeback(0, 5'd7);
      tick();
      clear_inputs();
      #1;
      checks++;
      if ((busy_mask_o !== 32'h0) || (underflow_o !== 1'b0)) begin
         errors++;
         $display("[TB] FAIL r7_drain: got mask %h uf %b expected 0 0", busy_mask_o, underflow_o);
      end
   endtask

   // Counter saturates at CMAX = 3 instead of wrapping.
   task automatic test_saturation();
      clear_inputs();
      issue(0, 5'd8);
      issue(1, 5'd8);
      tick();
      tick();
      clear_inputs();
      chk_w_reg_i[0] = 5'd8;
      #1;
      checks++;
      if ((busy_mask_o !== 32'h0000_0100) || (ready_o[0] !== 1'b0)) begin
         errors++;
         $display("[TB] FAIL r8_saturate: got mask %h rdy %b expected 00000100 0", busy_mask_o, ready_o[0]);
      end
      writeback(0, 5'd8);
      writeback(1, 5'd8);
      tick();
      clear_inputs();
      #1;
      checks++;
      if (busy_mask_o !== 32'h0000_0100) begin
         errors++;
         $display("[TB] FAIL r8_one_left: got %h expected %h", busy_mask_o, 32'h100);
      end
      writeback(1, 5'd8);
      tick();
      clear_inputs();
      #1;
      checks++;
      if ((busy_mask_o !== 32'h0) || (underflow_o !== 1'b0)) begin
         errors++;
         $display("[TB] FAIL r8_drain: got mask %h uf %b expected 0 0", busy_mask_o, underflow_o);
      end
   endtask

   // Dual issue to r3, two separate writebacks, then an extra one underflows.
   task automatic test_dual_underflow();
      clear_inputs();
      issue(0, 5'd3);
      issue(1, 5'd3);
      tick();
      clear_inputs();
      writeback(0, 5'd3);
      tick();
      clear_inputs();
      chk_r_reg_i[1][1] = 5'd3;
      #1;
      checks++;
      if ((busy_mask_o !== 32'h0000_0008) || (ready_o !== 2'b01)) begin
         errors++;
         $display("[TB] FAIL r3_after_first_wb: got mask %h rdy %b expected 00000008 01", busy_mask_o, ready_o);
      end
      writeback(1, 5'd3);
      tick();
      wb_valid_i = '0;
      #1;
      checks++;
      if ((busy_mask_o !== 32'h0) || (ready_o !== 2'b11)) begin
         errors++;
         $display("[TB] FAIL r3_after_second_wb: got mask %h rdy %b expected 0 11", busy_mask_o, ready_o);
      end
      writeback(0, 5'd3);
      tick();
      clear_inputs();
      #1;
      checks++;
      if ((underflow_o !== 1'b1) || (busy_mask_o !== 32'h0)) begin
         errors++;
         $display("[TB] FAIL r3_underflow: got uf %b mask %h expected 1 0", underflow_o, busy_mask_o);
      end
   endtask

   // Flush beats a simultaneous writeback and issue. The sticky flag is kept.
   task automatic test_flush();
      clear_inputs();
      issue(0, 5'd4);
      issue(1, 5'd9);
      tick();
      clear_inputs();
      issue(1, 5'd31);
      tick();
      clear_inputs();
      #1;
      checks++;
      if (busy_mask_o !== 32'h8000_0210) begin
         errors++;
         $display("[TB] FAIL flush_pre_mask: got %h expected %h", busy_mask_o, 32'h8000_0210);
      end
      flush_i = 1'b1;
      writeback(0, 5'd4);
      issue(0, 5'd10);
      tick();
      clear_inputs();
      chk_r_reg_i[0][0] = 5'd4;
      chk_r_reg_i[0][1] = 5'd9;
      chk_w_reg_i[0]    = 5'd31;
      chk_r_reg_i[1][0] = 5'd10;
      #1;
      checks++;
      if ((busy_mask_o !== 32'h0) || (ready_o !== 2'b11)) begin
         errors++;
         $display("[TB] FAIL flush_clear: got mask %h rdy %b expected 0 11", busy_mask_o, ready_o);
      end
      checks++;
      if (underflow_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL flush_keeps_uf: got %b expected 1", underflow_o);
      end
   endtask

   // Asynchronous reset mid-cycle, then r0 traffic is ignored.
   task automatic test_async_reset_r0();
      clear_inputs();
      issue(0, 5'd12);
      tick();
      clear_inputs();
      #1;
      checks++;
      if (busy_mask_o !== 32'h0000_1000) begin
         errors++;
         $display("[TB] FAIL r12_busy: got %h expected %h", busy_mask_o, 32'h1000);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ((busy_mask_o !== 32'h0) || (underflow_o !== 1'b0)) begin
         errors++;
         $display("[TB] FAIL async_reset: got mask %h uf %b expected 0 0", busy_mask_o, underflow_o);
      end
      tick();
      rst_n = 1'b1;
      tick();
      issue(0, 5'd0);
      issue(1, 5'd0);
      writeback(0, 5'd0);
      writeback(1, 5'd0);
      tick();
      writeback(0, 5'd0);
      is_fire_i = '0;
      tick();
      clear_inputs();
      #1;
      checks++;
      if ((busy_mask_o !== 32'h0) || (underflow_o !== 1'b0) || (ready_o !== 2'b11)) begin
         errors++;
         $display("[TB] FAIL r0_ignored: got mask %h uf %b rdy %b expected 0 0 11",
                  busy_mask_o, underflow_o, ready_o);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single_issue();
      test_same_cycle();
      test_saturation();
      test_dual_underflow();
      test_flush();
      test_async_reset_r0();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Per-register scoreboard for the dual-issue pipeline.
- Tracks outstanding writes from long-latency instructions (mul, div, load) from issue until writeback.
- Returns per-slot ready qualifiers that the issue stage ANDs into its issue decision.
- Sits beside the issue stage. Issue-stage pair checks (WAW/RAW within a pair, structural conflicts) stay in the issue stage and are not duplicated here.

Parameters:
- REG_NUM, 32: number of architectural GPRs. r0 is never tracked.
- CNT_W, 2: width of each per-register outstanding-write counter. Max count CMAX = 2^CNT_W - 1.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; all long-latency ops in flight are killed
- is_fire_i  in  2  slot k actually issues this cycle (the issue stage's is_o)
- is_long_i  in  2  slot k is a long-latency register writer
- is_w_reg_i  in  2x5  destination register of slot k
- chk_r_reg_i  in  2x2x5  source registers of the candidate instruction in slot k
- chk_w_reg_i  in  2x5  destination register of the candidate instruction in slot k
- wb_valid_i  in  2  long-latency writeback port j completes this cycle
- wb_w_reg_i  in  2x5  register written by writeback port j
- ready_o  out  2  slot k has no hazard against outstanding long writes
- busy_mask_o  out  REG_NUM  registered; bit r = (cnt[r] != 0)
- underflow_o  out  1  sticky error flag: a writeback arrived for a register whose count was 0

Behaviour:
- Reset (async, rst_n low): all cnt = 0, busy_mask_o = 0, underflow_o = 0.
- ready_o is combinational from registered state only, with no input-to-output path from is_fire_i or wb_*. busy(r) = cnt[r] != 0, and busy(0) = 0 always.
- ready_o[k] = !busy(chk_r_reg_i[k][0]) && !busy(chk_r_reg_i[k][1]) && !busy(chk_w_reg_i[k]) && (cnt[chk_w_reg_i[k]] != CMAX).
  - The busy-destination term avoids WAW against a long op.
  - The CMAX term guards counter saturation and is redundant while busy blocks.
- A same-cycle writeback does not make ready_o rise in that cycle; readiness appears the cycle after the counter reaches 0. No bypass.
- Increment for register r: number of slots k with is_fire_i[k] && is_long_i[k] && is_w_reg_i[k]==r && r!=0. Range 0..2.
- Decrement for register r: number of ports j with wb_valid_i[j] && wb_w_reg_i[j]==r && r!=0. Range 0..2.
- Update rule: next cnt[r] = cnt[r] + inc - dec, computed at CNT_W+2 bits signed.
  - If the result is < 0: next cnt[r] = 0 and underflow_o is set, and stays set until reset.
  - If the result is > CMAX: next cnt[r] = CMAX. This is a protocol violation; no flag is raised.
- Simultaneous issue and writeback to the same register in one cycle: both apply. Net change is 0 for one of each.
- Writes to r0, on either port, are ignored entirely.
- flush_i has priority over all updates in its cycle:
  - All cnt are cleared to 0 on the next edge.
  - Issue increments and writebacks in that cycle are discarded.
  - underflow_o keeps its value.
- Writebacks arriving after a flush for killed ops must not occur; the LSU and mul/div drop them. If one does arrive, it sets underflow_o.
- busy_mask_o is registered from next-state: it equals the busy set visible to ready_o in the same cycle.

Test Plan:
- Reset, then idle: busy_mask_o = 0, ready_o = 2'b11 for any register indices, underflow_o = 0.
- Issue a long op on slot0 writing r5. Next cycle: candidate with chk_r_reg_i[0][0] = 5 gives ready_o[0] = 0, busy_mask_o[5] = 1. Writeback wb_w_reg_i[0] = 5: ready_o[0] = 0 in that cycle and 1 the following cycle.
- Issue on r7 and writeback on r7 in the same cycle while cnt[7] = 1: cnt[7] stays 1, busy_mask_o[7] stays 1.
- Both slots issue long ops writing r3 (cnt 0→2). Two writebacks follow on separate cycles: busy clears only after the second. A third writeback to r3 then sets underflow_o = 1, and cnt stays 0.
- Long ops in flight on r4, r9, r31, then assert flush_i together with a writeback to r4 and a long issue to r10: next cycle busy_mask_o = 0, ready_o = 2'b11, underflow_o unchanged.
- Long issue to r0 and a writeback to r0: no state change, no underflow. Deassert rst_n mid-sequence with r12 busy: busy_mask_o = 0 and underflow_o = 0 immediately, without waiting for a clock edge.
